// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle control path: opcodes, FSM state
// encodings, instruction classes and the mux/ALU select encodings.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_JUMP,
    CLS_RTYPE,
    CLS_IARITH,
    CLS_BRANCH,
    CLS_LI,
    CLS_LUI,
    CLS_LWI,
    CLS_SWI,
    CLS_LW,
    CLS_SW,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000001;
  localparam logic [5:0] OP_BEQ = 6'b100000;
  localparam logic [5:0] OP_BNE = 6'b100001;
  localparam logic [5:0] OP_BLT = 6'b100010;
  localparam logic [5:0] OP_BLE = 6'b100011;
  localparam logic [5:0] OP_LI  = 6'b111001;
  localparam logic [5:0] OP_LUI = 6'b111010;
  localparam logic [5:0] OP_LWI = 6'b111011;
  localparam logic [5:0] OP_SWI = 6'b111100;
  localparam logic [5:0] OP_LW  = 6'b111101;
  localparam logic [5:0] OP_SW  = 6'b111110;

  localparam logic [1:0] PC_SEL_INC    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_LI  = 2'b10;
  localparam logic [1:0] WB_SEL_LUI = 2'b11;

  localparam logic [2:0] ALU_OP_ADD = 3'b010;
  localparam logic [2:0] ALU_OP_SUB = 3'b011;

  // Branch condition from the low two opcode bits: BEQ, BNE, BLT, BLE.
  function automatic logic branch_taken(input logic [1:0] cond,
                                        input logic zero,
                                        input logic lt);
    case (cond)
      2'b00:   branch_taken = zero;
      2'b01:   branch_taken = !zero;
      2'b10:   branch_taken = lt;
      default: branch_taken = lt | zero;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: maps the 6-bit opcode onto one instruction class.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class
);

  // Pure lookup; anything not listed is reported as illegal.
  always_comb begin
    op_class = CLS_ILLEGAL;
    casez (opcode)
      OP_NOP:    op_class = CLS_NOP;
      OP_J:      op_class = CLS_JUMP;
      6'b010???: op_class = CLS_RTYPE;
      6'b11001?: op_class = CLS_IARITH;
      6'b1101??: op_class = CLS_IARITH;
      6'b1000??: op_class = CLS_BRANCH;
      OP_LI:     op_class = CLS_LI;
      OP_LUI:    op_class = CLS_LUI;
      OP_LWI:    op_class = CLS_LWI;
      OP_SWI:    op_class = CLS_SWI;
      OP_LW:     op_class = CLS_LW;
      OP_SW:     op_class = CLS_SW;
      default:   op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Optional feature: define MEM_WAIT_EN to stall FETCH and MEM on mem_ready.
module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       ir_we,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic [2:0] alu_op,
  output logic       alu_b_imm,
  output logic       dmem_re,
  output logic       dmem_we,
  output logic       addr_sel,
  output logic [2:0] state,
  output logic       illegal
);

  state_t    cur_state;
  state_t    next_state;
  op_class_t op_class;
  logic      mem_go;

`ifdef MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go = 1'b1;
`endif

  ctrl_decode u_decode (
    .opcode   (opcode),
    .op_class (op_class)
  );

  assign state = cur_state;

  // State register; reset lands in FETCH without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= ST_FETCH;
    else        cur_state <= next_state;
  end

  // Next state and control outputs; all outputs held low while in reset.
  always_comb begin
    next_state = ST_FETCH;
    pc_we      = 1'b0;
    pc_sel     = PC_SEL_INC;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = WB_SEL_ALU;
    alu_op     = 3'b000;
    alu_b_imm  = 1'b0;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    addr_sel   = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (cur_state)
        ST_FETCH: begin
          ir_we      = mem_go;
          pc_we      = mem_go;
          pc_sel     = PC_SEL_INC;
          next_state = mem_go ? ST_DECODE : ST_FETCH;
        end
        ST_DECODE: begin
          case (op_class)
            CLS_NOP: next_state = ST_FETCH;
            CLS_JUMP: begin
              pc_we      = 1'b1;
              pc_sel     = PC_SEL_JUMP;
              next_state = ST_FETCH;
            end
            CLS_RTYPE, CLS_IARITH, CLS_BRANCH, CLS_LW, CLS_SW:
              next_state = ST_EXEC;
            CLS_LI, CLS_LUI:   next_state = ST_WB;
            CLS_LWI, CLS_SWI:  next_state = ST_MEM;
            default: begin
              illegal    = 1'b1;
              next_state = ST_FETCH;
            end
          endcase
        end
        ST_EXEC: begin
          case (op_class)
            CLS_RTYPE: begin
              alu_op     = opcode[2:0];
              next_state = ST_WB;
            end
            CLS_IARITH: begin
              alu_op     = opcode[2:0];
              alu_b_imm  = 1'b1;
              next_state = ST_WB;
            end
            CLS_BRANCH: begin
              alu_op     = ALU_OP_SUB;
              next_state = ST_FETCH;
              if (branch_taken(opcode[1:0], alu_zero, alu_lt)) begin
                pc_we  = 1'b1;
                pc_sel = PC_SEL_BRANCH;
              end
            end
            CLS_LW, CLS_SW: begin
              alu_op     = ALU_OP_ADD;
              alu_b_imm  = 1'b1;
              next_state = ST_MEM;
            end
            default: next_state = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          case (op_class)
            CLS_LW: begin
              dmem_re    = 1'b1;
              addr_sel   = 1'b1;
              next_state = mem_go ? ST_WB : ST_MEM;
            end
            CLS_LWI: begin
              dmem_re    = 1'b1;
              next_state = mem_go ? ST_WB : ST_MEM;
            end
            CLS_SW: begin
              dmem_we    = 1'b1;
              addr_sel   = 1'b1;
              next_state = mem_go ? ST_FETCH : ST_MEM;
            end
            CLS_SWI: begin
              dmem_we    = 1'b1;
              next_state = mem_go ? ST_FETCH : ST_MEM;
            end
            default: next_state = ST_FETCH;
          endcase
        end
        ST_WB: begin
          rf_we      = 1'b1;
          next_state = ST_FETCH;
          case (op_class)
            CLS_LW, CLS_LWI: wb_sel = WB_SEL_MEM;
            CLS_LI:          wb_sel = WB_SEL_LI;
            CLS_LUI:         wb_sel = WB_SEL_LUI;
            default:         wb_sel = WB_SEL_ALU;
          endcase
        end
        default: next_state = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (default build, MEM_WAIT_EN undefined).
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       ir_we;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [2:0] alu_op;
    logic       alu_b_imm;
    logic       dmem_re;
    logic       dmem_we;
    logic       addr_sel;
    logic       illegal;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       alu_lt;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       ir_we;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic [2:0] alu_op;
  logic       alu_b_imm;
  logic       dmem_re;
  logic       dmem_we;
  logic       addr_sel;
  logic [2:0] state;
  logic       illegal;

  int   total;
  int   bad;
  vec_t scoreboard[$];

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .alu_zero  (alu_zero),
    .alu_lt    (alu_lt),
    .mem_ready (mem_ready),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .ir_we     (ir_we),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .alu_op    (alu_op),
    .alu_b_imm (alu_b_imm),
    .dmem_re   (dmem_re),
    .dmem_we   (dmem_we),
    .addr_sel  (addr_sel),
    .state     (state),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t observed();
    vec_t o;
    o.st        = state;
    o.pc_we     = pc_we;
    o.pc_sel    = pc_sel;
    o.ir_we     = ir_we;
    o.rf_we     = rf_we;
    o.wb_sel    = wb_sel;
    o.alu_op    = alu_op;
    o.alu_b_imm = alu_b_imm;
    o.dmem_re   = dmem_re;
    o.dmem_we   = dmem_we;
    o.addr_sel  = addr_sel;
    o.illegal   = illegal;
    return o;
  endfunction

  function automatic vec_t fetchVec();
    vec_t v = '0;
    v.ir_we = 1'b1;
    v.pc_we = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input vec_t exp);
    vec_t obs;
    obs = observed();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%05h expected=%05h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: expected per-cycle control vectors for one instruction.
  task automatic applyStimulus(input logic [5:0] op, input logic zero, input logic lt);
    vec_t v;
    logic is_rtype, is_iarith, is_branch, taken;
    opcode    = op;
    alu_zero  = zero;
    alu_lt    = lt;
    is_rtype  = (op[5:3] == 3'b010);
    is_iarith = (op[5:3] == 3'b110) && (op[2:1] != 2'b00);
    is_branch = (op[5:2] == 4'b1000);
    case (op[1:0])
      2'b00:   taken = zero;
      2'b01:   taken = ~zero;
      2'b10:   taken = lt;
      default: taken = lt || zero;
    endcase
    scoreboard.push_back(fetchVec());
    v = '0; v.st = 3'd1;
    if (op == 6'b000000) begin
      scoreboard.push_back(v);
    end else if (op == 6'b000001) begin
      v.pc_we = 1'b1; v.pc_sel = 2'b10;
      scoreboard.push_back(v);
    end else if (is_rtype || is_iarith) begin
      scoreboard.push_back(v);
      v = '0; v.st = 3'd2; v.alu_op = op[2:0]; v.alu_b_imm = is_iarith;
      scoreboard.push_back(v);
      v = '0; v.st = 3'd4; v.rf_we = 1'b1; v.wb_sel = 2'b00;
      scoreboard.push_back(v);
    end else if (is_branch) begin
      scoreboard.push_back(v);
      v = '0; v.st = 3'd2; v.alu_op = 3'b011;
      if (taken) begin v.pc_we = 1'b1; v.pc_sel = 2'b01; end
      scoreboard.push_back(v);
    end else if (op == 6'b111101 || op == 6'b111110) begin
      scoreboard.push_back(v);
      v = '0; v.st = 3'd2; v.alu_op = 3'b010; v.alu_b_imm = 1'b1;
      scoreboard.push_back(v);
      v = '0; v.st = 3'd3; v.addr_sel = 1'b1;
      if (op == 6'b111101) v.dmem_re = 1'b1; else v.dmem_we = 1'b1;
      scoreboard.push_back(v);
      if (op == 6'b111101) begin
        v = '0; v.st = 3'd4; v.rf_we = 1'b1; v.wb_sel = 2'b01;
        scoreboard.push_back(v);
      end
    end else if (op == 6'b111011 || op == 6'b111100) begin
      scoreboard.push_back(v);
      v = '0; v.st = 3'd3;
      if (op == 6'b111011) v.dmem_re = 1'b1; else v.dmem_we = 1'b1;
      scoreboard.push_back(v);
      if (op == 6'b111011) begin
        v = '0; v.st = 3'd4; v.rf_we = 1'b1; v.wb_sel = 2'b01;
        scoreboard.push_back(v);
      end
    end else if (op == 6'b111001 || op == 6'b111010) begin
      scoreboard.push_back(v);
      v = '0; v.st = 3'd4; v.rf_we = 1'b1;
      v.wb_sel = (op == 6'b111001) ? 2'b10 : 2'b11;
      scoreboard.push_back(v);
    end else begin
      v.illegal = 1'b1;
      scoreboard.push_back(v);
    end
  endtask

  // Pop one expected vector, compare, optionally advance one clock.
  task automatic stepOne(input string tag, input bit advance);
    vec_t e;
    e = scoreboard.pop_front();
    checkOutput(tag, e);
    if (advance) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drainScoreboard(input string tag);
    while (scoreboard.size() > 0) stepOne(tag, 1'b1);
  endtask

  initial begin
    vec_t zeroVec;
    total     = 0;
    bad       = 0;
    zeroVec   = '0;
    rst_n     = 1'b0;
    opcode    = 6'b000001;
    alu_zero  = 1'b0;
    alu_lt    = 1'b0;
    mem_ready = 1'b0;

    #2;
    checkOutput("reset_t0", zeroVec);
    @(posedge clk); #1;
    checkOutput("reset_held", zeroVec);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    applyStimulus(6'b110010, 1'b0, 1'b0); drainScoreboard("addi");
    applyStimulus(6'b010101, 1'b0, 1'b0); drainScoreboard("rtype");
    applyStimulus(6'b110111, 1'b0, 1'b0); drainScoreboard("iarith_top");
    applyStimulus(6'b100010, 1'b0, 1'b1); drainScoreboard("blt_taken");
    applyStimulus(6'b100010, 1'b0, 1'b0); drainScoreboard("blt_not");
    applyStimulus(6'b100000, 1'b1, 1'b0); drainScoreboard("beq_taken");
    applyStimulus(6'b100001, 1'b1, 1'b0); drainScoreboard("bne_not");
    applyStimulus(6'b100011, 1'b1, 1'b0); drainScoreboard("ble_eq");
    applyStimulus(6'b111101, 1'b0, 1'b0); drainScoreboard("lw");
    applyStimulus(6'b111110, 1'b0, 1'b0); drainScoreboard("sw");
    applyStimulus(6'b111011, 1'b0, 1'b0); drainScoreboard("lwi");
    applyStimulus(6'b111001, 1'b0, 1'b0); drainScoreboard("li");
    applyStimulus(6'b111010, 1'b0, 1'b0); drainScoreboard("lui");
    applyStimulus(6'b000000, 1'b0, 1'b0); drainScoreboard("nop");
    applyStimulus(6'b000001, 1'b0, 1'b0); drainScoreboard("jump");
    applyStimulus(6'b101010, 1'b0, 1'b0); drainScoreboard("illegal_101010");
    applyStimulus(6'b110001, 1'b0, 1'b0); drainScoreboard("illegal_110001");
    applyStimulus(6'b111111, 1'b0, 1'b0); drainScoreboard("illegal_111111");

    // SWI interrupted by reset while in MEM
    applyStimulus(6'b111100, 1'b0, 1'b0);
    stepOne("swi_fetch", 1'b1);
    stepOne("swi_decode", 1'b1);
    stepOne("swi_mem", 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("swi_async_reset", zeroVec);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    applyStimulus(6'b111100, 1'b0, 1'b0); drainScoreboard("swi_full");
    checkOutput("final_fetch", fetchVec());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
